fwd_ctrl_unit: RTL and testbench

//   Forwarding and hazard controller; drives the 2-bit operand selects of the EX-stage

---
 rtl/fwd_ctrl_unit_pkg.sv | 18 +
 rtl/fwd_ctrl_unit_if.sv | 36 +++
 rtl/fwd_ctrl_unit_sel.sv | 38 +++
 rtl/fwd_ctrl_unit.sv | 115 +++++++++++
 tb/tb_fwd_ctrl_unit.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fwd_ctrl_unit_pkg.sv
// Shared constants for the forwarding/hazard controller and the EX datapath.
// Contents:
//   fwd_sel_t   - 2-bit operand select driven into the EX-stage data_mux_3
//   is_producer - true when a shadow entry will write a non-zero register
package fwd_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,  // regfile / ID-stage value
    FWD_MEM = 2'd1,  // ALU result currently in MEM
    FWD_WB  = 2'd2   // result currently in WB
  } fwd_sel_t;

  // Register 0 is hard-wired, so an entry targeting it is never a producer.
  function automatic logic is_producer(input logic vld, input logic wr, input logic rd_nz);
    return vld & wr & rd_nz;
  endfunction

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// Bus between the ID/EX pipeline control and the forwarding controller.
// Parameters: RA_W register-address width, CNT_W stall counter width.
// master: pipeline side, drives hold/flush and the decoded ID fields,
//         receives operand selects, stall and the stall counter.
// slave : forwarding controller, the opposite directions.
interface fwd_ctrl_unit_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
);
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [RA_W-1:0]  id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_reg_write, id_mem_read,
    input  ex_fwd_a, ex_fwd_b, stall, stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_reg_write, id_mem_read,
    output ex_fwd_a, ex_fwd_b, stall, stall_count
  );
endinterface

// File: rtl/fwd_ctrl_unit_sel.sv
// fwd_sel: combinational operand-select comparator, one per EX operand.
// Ports:
//   src, src_used              - source register of the ID instruction and its use flag
//   ex_vld, ex_rd, ex_wr       - shadow entry of the instruction now in EX
//   mem_vld, mem_rd, mem_wr    - shadow entry of the instruction now in MEM
//   sel                        - select to register for the next EX cycle
module fwd_sel
  import fwd_ctrl_unit_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            src_used,
  input  logic            ex_vld,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_wr,
  input  logic            mem_vld,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_wr,
  output fwd_sel_t        sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = src_used & is_producer(ex_vld, ex_wr, |ex_rd) & (ex_rd == src);
  assign mem_hit = src_used & is_producer(mem_vld, mem_wr, |mem_rd) & (mem_rd == src);

  // The younger producer (EX now, MEM next cycle) holds the newer value.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)
      sel = FWD_MEM;
    else if (mem_hit)
      sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: forwarding and load-use hazard controller beside ID/EX.
// Tracks the destination info of the EX and MEM instructions, registers the
// EX operand selects for the instruction leaving ID, and raises a
// combinational stall for a load followed directly by a consumer.
// Ports:
//   clk, rst - pipeline clock (rising edge), asynchronous active-high reset
//   bus      - fwd_ctrl_unit_if slave: hold/flush, decoded ID fields in;
//              ex_fwd_a/b, stall, stall_count out
module fwd_ctrl_unit
  import fwd_ctrl_unit_pkg::*;
#(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  fwd_ctrl_unit_if.slave bus
);

  // Shadow of the EX and MEM stages. No WB entry is kept: distance-3
  // dependencies are served by regfile write-through, so WB info would
  // never be read here.
  logic            ex_vld;
  logic [RA_W-1:0] ex_rd;
  logic            ex_wr;
  logic            ex_ld;
  logic            mem_vld;
  logic [RA_W-1:0] mem_rd;
  logic            mem_wr;

  fwd_sel_t        fwd_a_q;
  fwd_sel_t        fwd_b_q;
  fwd_sel_t        sel_a;
  fwd_sel_t        sel_b;
  logic [CNT_W-1:0] cnt_q;

  logic            hazard;
  logic            stall;
  logic            accept;

  fwd_sel #(.RA_W(RA_W)) u_sel_a (
    .src      (bus.id_rs),
    .src_used (bus.id_rs_used),
    .ex_vld   (ex_vld),
    .ex_rd    (ex_rd),
    .ex_wr    (ex_wr),
    .mem_vld  (mem_vld),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .sel      (sel_a)
  );

  fwd_sel #(.RA_W(RA_W)) u_sel_b (
    .src      (bus.id_rt),
    .src_used (bus.id_rt_used),
    .ex_vld   (ex_vld),
    .ex_rd    (ex_rd),
    .ex_wr    (ex_wr),
    .mem_vld  (mem_vld),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .sel      (sel_b)
  );

  // A load in EX cannot forward to the instruction right behind it.
  always_comb begin
    hazard = bus.id_valid & is_producer(ex_vld, ex_wr, |ex_rd) & ex_ld &
             ((bus.id_rs_used & (bus.id_rs == ex_rd)) |
              (bus.id_rt_used & (bus.id_rt == ex_rd)));
    stall  = hazard & ~bus.flush;
    accept = bus.id_valid & ~bus.flush & ~stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld  <= 1'b0;
      ex_rd   <= '0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_vld <= 1'b0;
      mem_rd  <= '0;
      mem_wr  <= 1'b0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else if (!bus.hold) begin
      mem_vld <= ex_vld;
      mem_rd  <= ex_rd;
      mem_wr  <= ex_wr;
      if (accept) begin
        ex_vld  <= 1'b1;
        ex_rd   <= bus.id_rd;
        ex_wr   <= bus.id_reg_write;
        ex_ld   <= bus.id_mem_read;
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end else begin
        ex_vld  <= 1'b0;
        ex_rd   <= '0;
        ex_wr   <= 1'b0;
        ex_ld   <= 1'b0;
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
module tb_fwd_ctrl_unit;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // Expected {ex_fwd_a, ex_fwd_b} for each instruction slot entering EX.
  logic [3:0] exp_q[$];

  fwd_ctrl_unit_if #(.RA_W(5), .CNT_W(32)) bus ();

  fwd_ctrl_unit #(.RA_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One ID slot: drive at negedge, check the combinational stall, push the
  // expected selects for the following EX cycle, then pop and compare them
  // once the edge has passed.
  task automatic cyc(input string tag, input logic v,
                     input logic [4:0] rs, input logic ru,
                     input logic [4:0] rt, input logic tu,
                     input logic [4:0] rd, input logic w, input logic ld,
                     input logic fl, input logic hd,
                     input logic est, input logic [1:0] ea, input logic [1:0] eb);
    logic [3:0] e;
    @(negedge clk);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rs_used   = ru;
    bus.id_rt        = rt;
    bus.id_rt_used   = tu;
    bus.id_rd        = rd;
    bus.id_reg_write = w;
    bus.id_mem_read  = ld;
    bus.flush        = fl;
    bus.hold         = hd;
    #1;
    check({tag, " stall"}, 32'(bus.stall), 32'(est));
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " fwd_a"}, 32'(bus.ex_fwd_a), 32'(e[3:2]));
      check({tag, " fwd_b"}, 32'(bus.ex_fwd_b), 32'(e[1:0]));
    end
  endtask

  task automatic nop(input string tag);
    cyc(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rs_used = 0; bus.id_rt_used = 0;
    bus.id_rd = '0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst fwd_a", 32'(bus.ex_fwd_a), 32'd0);
    check("rst fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    check("rst stall", 32'(bus.stall), 32'd0);
    check("rst count", bus.stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //          tag       v rs  ru rt  tu rd  w ld fl hd st a  b
    cyc("t1 add",   1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t1 sub",   1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0, 0, 2'd1, 2'd0);
    nop("t1 d0"); nop("t1 d1");

    cyc("t2 add",   1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("t2 gap");
    cyc("t2 or",    1, 5'd7, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0, 0, 2'd0, 2'd2);
    nop("t2 d0"); nop("t2 d1");
    cyc("t2 add0",  1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t2 sub0",  1, 5'd0, 1, 5'd0, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t2 or0",   1, 5'd7, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("t2 d2"); nop("t2 d3");

    cyc("t3 add1",  1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t3 add2",  1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t3 and",   1, 5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0, 0, 0, 2'd1, 2'd1);
    nop("t3 d0"); nop("t3 d1");

    cyc("t4 lw",    1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    check("t4 cnt0", bus.stall_count, 32'd0);
    cyc("t4 stall", 1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    check("t4 cnt1", bus.stall_count, 32'd1);
    cyc("t4 add",   1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 0, 0, 0, 2'd2, 2'd0);
    nop("t4 d0"); nop("t4 d1");
    cyc("t4 lw2",   1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("t4 inval", 0, 5'd4, 1, 5'd4, 1, 5'd9, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("t4 d2"); nop("t4 d3");

    cyc("t5 lw",    1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    cyc("t5 flush", 1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 1, 0, 0, 2'd0, 2'd0);
    check("t5 cntf", bus.stall_count, 32'd1);
    nop("t5 d0"); nop("t5 d1");
    cyc("t5 lw2",   1, 5'd1, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("t5 hold",  1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 0, 1, 1, 2'd0, 2'd0);
      check("t5 cnth", bus.stall_count, 32'd1);
    end
    cyc("t5 rel",   1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 0, 0, 1, 2'd0, 2'd0);
    check("t5 cnt2", bus.stall_count, 32'd2);
    cyc("t5 add",   1, 5'd4, 1, 5'd1, 1, 5'd9, 1, 0, 0, 0, 0, 2'd2, 2'd0);
    nop("t5 d2"); nop("t5 d3");

    cyc("t6 add",   1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc("t6 sub",   1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0, 0, 2'd1, 2'd0);
    cyc("t6 lw",    1, 5'd5, 1, 5'd0, 0, 5'd4, 1, 1, 0, 0, 0, 2'd1, 2'd0);
    @(negedge clk);
    bus.id_valid = 1; bus.id_rs = 5'd4; bus.id_rs_used = 1;
    bus.id_rt = 5'd1; bus.id_rt_used = 1; bus.id_rd = 5'd9;
    bus.id_reg_write = 1; bus.id_mem_read = 0;
    #1;
    check("t6 pre stall", 32'(bus.stall), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6 rst stall", 32'(bus.stall), 32'd0);
    check("t6 rst fwd_a", 32'(bus.ex_fwd_a), 32'd0);
    check("t6 rst fwd_b", 32'(bus.ex_fwd_b), 32'd0);
    check("t6 rst count", bus.stall_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("t6 post",  1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    nop("t6 d0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
